// File: rtl/soc_pkg.sv
// Shared SoC types for the memory port arbiter: FSM state, access owner and width defaults.
package soc_pkg;

  localparam int SOC_XLEN   = 32;
  localparam int SOC_ADDR_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and load/store (D), one access at a time.
// Optional I-starvation guard is enabled with the ARB_STARVE_GUARD_EN macro.
module mem_port_arbiter
  import soc_pkg::*;
#(
  parameter int ADDR_W       = SOC_ADDR_W,
  parameter int DATA_W       = SOC_XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [ADDR_W-1:0]     i_addr_i,
  output logic                  i_gnt_o,
  output logic                  i_rvalid_o,
  output logic [DATA_W-1:0]     i_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_W-1:0]     d_addr_i,
  input  logic [DATA_W-1:0]     d_wdata_i,
  input  logic [DATA_W/8-1:0]   d_be_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_W-1:0]     d_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                i_rvalid_q, i_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant_d;
  logic                grant_i;
  logic                starved;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

  // Counts D grants taken while a fetch is waiting; any I grant or idle I port clears it.
  always_comb begin
    starve_d = starve_q;
    if (!i_req_i || grant_i) begin
      starve_d = '0;
    end else if (grant_d && !starved) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starved = 1'b0;
`endif

  // Arbitration, request latching and completion capture.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req_i && !(starved && i_req_i)) begin
          grant_d = 1'b1;
          state_d = ACTIVE;
          owner_d = OWN_D;
          we_d    = d_we_i;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
          be_d    = d_be_i;
        end else if (i_req_i) begin
          grant_i = 1'b1;
          state_d = ACTIVE;
          owner_d = OWN_I;
          we_d    = 1'b0;
          addr_d  = i_addr_i;
          wdata_d = '0;
          be_d    = '1;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (mem_ready_i) begin
          state_d = IDLE;
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = we_q ? '0 : mem_rdata_i;
          end else begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = mem_rdata_i;
          end
        end else begin
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched access and response registers; reset drops any access in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign d_gnt_o     = grant_d & ~rst_i;
  assign i_gnt_o     = grant_i & ~rst_i;
  assign i_rvalid_o  = i_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = (state_q == ACTIVE);
  assign mem_we_o    = (state_q == ACTIVE) & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard queues and a wait-state memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        i_req_i = 1'b0;
  logic [31:0] i_addr_i = 32'h0;
  logic        i_gnt_o, i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_addr_i = 32'h0;
  logic [31:0] d_wdata_i = 32'h0;
  logic [3:0]  d_be_i = 4'h0;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } acc_t;

  typedef struct {
    bit          is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wt;
    logic [31:0] exp;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  acc_t        exp_mem_q[$];
  byte         gnt_log[$];
  int          mem_wait = 0;
  bit          mem_hold = 1'b0;
  bit          mem_force = 1'b0;
  int          act_cnt = 0;
  int          d_gnt_cyc = 0, i_gnt_cyc = 0, d_rv_cyc = 0, i_rv_cyc = 0, rv_count = 0;
  logic [31:0] last_d_rdata = 32'h0, last_i_rdata = 32'h0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor and memory responder, both sampled on the falling edge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      mem_ready_i = 1'b0;
      act_cnt = 0;
    end else begin
      if (d_gnt_o || i_gnt_o) chk("single_gnt", {31'd0, d_gnt_o & i_gnt_o}, 32'd0);
      if (d_gnt_o) begin
        exp_d_q.push_back(d_we_i ? 32'h0 : mem_f(d_addr_i));
        exp_mem_q.push_back('{d_we_i, d_addr_i, d_wdata_i, d_be_i});
        gnt_log.push_back("D");
        d_gnt_cyc = cyc;
      end
      if (i_gnt_o) begin
        exp_i_q.push_back(mem_f(i_addr_i));
        exp_mem_q.push_back('{1'b0, i_addr_i, 32'h0, 4'hF});
        gnt_log.push_back("I");
        i_gnt_cyc = cyc;
      end
      if (d_rvalid_o) begin
        rv_count++;
        d_rv_cyc = cyc;
        last_d_rdata = d_rdata_o;
        if (exp_d_q.size() == 0) chk("d_rvalid_unexpected", {31'd0, d_rvalid_o}, 32'd0);
        else chk("d_rdata", d_rdata_o, exp_d_q.pop_front());
      end
      if (i_rvalid_o) begin
        rv_count++;
        i_rv_cyc = cyc;
        last_i_rdata = i_rdata_o;
        if (exp_i_q.size() == 0) chk("i_rvalid_unexpected", {31'd0, i_rvalid_o}, 32'd0);
        else chk("i_rdata", i_rdata_o, exp_i_q.pop_front());
      end
      if (mem_req_o) begin
        if (exp_mem_q.size() == 0) begin
          chk("mem_req_unexpected", {31'd0, mem_req_o}, 32'd0);
        end else begin
          chk("mem_addr", mem_addr_o, exp_mem_q[0].addr);
          chk("mem_we", {31'd0, mem_we_o}, {31'd0, exp_mem_q[0].we});
          chk("mem_be", {28'd0, mem_be_o}, {28'd0, exp_mem_q[0].be});
          if (exp_mem_q[0].we) chk("mem_wdata", mem_wdata_o, exp_mem_q[0].wdata);
        end
        if (!mem_hold && act_cnt >= mem_wait) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = mem_f(mem_addr_o);
          if (exp_mem_q.size() != 0) void'(exp_mem_q.pop_front());
          act_cnt = 0;
        end else begin
          mem_ready_i = 1'b0;
          act_cnt++;
        end
      end else begin
        mem_ready_i = mem_force;
        mem_rdata_i = 32'h0BAD0BAD;
        act_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_gnt(input bit is_d, output int gcyc);
    bit got;
    got = 1'b0;
    gcyc = -1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk_i);
      if ((is_d ? d_gnt_o : i_gnt_o) === 1'b1) begin
        got = 1'b1;
        gcyc = cyc;
      end
    end
    if (!got) chk(is_d ? "d_gnt_timeout" : "i_gnt_timeout", {31'd0, got}, 32'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((exp_i_q.size() != 0 || exp_d_q.size() != 0 || mem_req_o) && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) chk("done_timeout", k, 0);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t vecs[6];
    int   g, g0, g1, g2, dg, ig, rv0;
    byte  exp_seq[6];

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,          4'hF, 0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,          4'hF, 0, 32'hDEAD_BFEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'h3, 3, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,          4'hF, 2, 32'hDEAD_BDEF};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,          4'hF, 1, 32'h2152_4013};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4'hF, 0, 32'h0};

    // Reset with both requests high: nothing may be granted.
    d_req_i = 1'b1;
    i_req_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("rst_d_gnt", {31'd0, d_gnt_o}, 32'd0);
    chk("rst_i_gnt", {31'd0, i_gnt_o}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_rvalid", {30'd0, i_rvalid_o, d_rvalid_o}, 32'd0);
    chk("rst_i_rdata", i_rdata_o, 32'd0);
    chk("rst_d_rdata", d_rdata_o, 32'd0);
    @(posedge clk_i);
    #1;
    d_req_i = 1'b0;
    i_req_i = 1'b0;
    rst_i = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      gnt_log.delete();
      rv0 = rv_count;
      mem_wait = vecs[v].wt;
      if (vecs[v].is_d) begin
        d_we_i = vecs[v].we;
        d_addr_i = vecs[v].addr;
        d_wdata_i = vecs[v].wdata;
        d_be_i = vecs[v].be;
        d_req_i = 1'b1;
      end else begin
        i_addr_i = vecs[v].addr;
        i_req_i = 1'b1;
      end
      wait_gnt(vecs[v].is_d, g);
      d_req_i = 1'b0;
      i_req_i = 1'b0;
      wait_done();
      if (vecs[v].is_d) begin
        chk($sformatf("vec%0d_d_rdata", v), last_d_rdata, vecs[v].exp);
        chk($sformatf("vec%0d_latency", v), d_rv_cyc - g, 32'(2 + vecs[v].wt));
      end else begin
        chk($sformatf("vec%0d_i_rdata", v), last_i_rdata, vecs[v].exp);
        chk($sformatf("vec%0d_latency", v), i_rv_cyc - g, 32'(2 + vecs[v].wt));
      end
      chk($sformatf("vec%0d_rvalid_count", v), rv_count - rv0, 32'd1);
      chk($sformatf("vec%0d_gnt_count", v), gnt_log.size(), 32'd1);
      if (gnt_log.size() != 0)
        chk($sformatf("vec%0d_gnt_port", v), {24'd0, gnt_log[0]}, vecs[v].is_d ? 32'h44 : 32'h49);
    end

    // Contention: D first, I granted in the cycle of d_rvalid.
    gnt_log.delete();
    mem_wait = 0;
    i_addr_i = 32'h10;
    d_addr_i = 32'h20;
    d_we_i = 1'b0;
    d_be_i = 4'hF;
    i_req_i = 1'b1;
    d_req_i = 1'b1;
    wait_gnt(1'b1, dg);
    d_req_i = 1'b0;
    wait_gnt(1'b0, ig);
    i_req_i = 1'b0;
    wait_done();
    chk("cont_i_gnt_cycle", ig - dg, 32'd2);
    chk("cont_i_gnt_with_d_rvalid", ig, d_rv_cyc);
    chk("cont_i_rvalid_cycle", i_rv_cyc - ig, 32'd2);
    chk("cont_gnt_count", gnt_log.size(), 32'd2);

    // Starvation: both held high, ready after one cycle.
`ifdef ARB_STARVE_GUARD_EN
    exp_seq = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44};
`else
    exp_seq = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44};
`endif
    gnt_log.delete();
    mem_wait = 0;
    d_addr_i = 32'h300;
    d_we_i = 1'b0;
    i_addr_i = 32'h304;
    d_req_i = 1'b1;
    i_req_i = 1'b1;
    for (int k = 0; k < 100 && gnt_log.size() < 6; k++) tick();
    d_req_i = 1'b0;
    i_req_i = 1'b0;
    wait_done();
    chk("starve_gnt_count", gnt_log.size(), 32'd6);
    for (int k = 0; k < 6 && k < gnt_log.size(); k++)
      chk($sformatf("starve_gnt%0d", k), {24'd0, gnt_log[k]}, {24'd0, exp_seq[k]});

    // Back-to-back fetches with incrementing addresses.
    gnt_log.delete();
    i_addr_i = 32'h0;
    i_req_i = 1'b1;
    wait_gnt(1'b0, g0);
    i_addr_i = 32'h4;
    wait_gnt(1'b0, g1);
    i_addr_i = 32'h8;
    wait_gnt(1'b0, g2);
    i_req_i = 1'b0;
    wait_done();
    chk("b2b_gap01", g1 - g0, 32'd2);
    chk("b2b_gap12", g2 - g1, 32'd2);
    chk("b2b_gnt_count", gnt_log.size(), 32'd3);
    chk("b2b_last_rdata", last_i_rdata, 32'hDEAD_BFE7);

    // Reset in the middle of an access, then a late ready in IDLE.
    mem_hold = 1'b1;
    i_addr_i = 32'h500;
    i_req_i = 1'b1;
    wait_gnt(1'b0, g);
    i_req_i = 1'b0;
    tick();
    chk("mid_mem_req_active", {31'd0, mem_req_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_i_q.delete();
    exp_mem_q.delete();
    mem_hold = 1'b0;
    rv0 = rv_count;
    @(negedge clk_i);
    chk("mid_rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("mid_rst_i_rvalid", {31'd0, i_rvalid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    mem_force = 1'b1;
    tick();
    tick();
    mem_force = 1'b0;
    tick();
    @(negedge clk_i);
    chk("idle_ready_no_rvalid", rv_count - rv0, 32'd0);
    chk("idle_ready_no_mem_req", {31'd0, mem_req_o}, 32'd0);
    @(posedge clk_i);
    #1;
    i_addr_i = 32'h504;
    i_req_i = 1'b1;
    wait_gnt(1'b0, g);
    i_req_i = 1'b0;
    wait_done();
    chk("post_rst_fetch", last_i_rdata, 32'hDEAD_BAEB);
    chk("post_rst_rvalid_count", rv_count - rv0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
